// File: rtl/test_result_mailbox_if.sv
// Bus and result-stream signals shared by the vscale firmware side and the
// result mailbox.
interface test_result_mailbox_if #(
    parameter int TAG_W = 8
);
    logic             bus_sel;
    logic             bus_we;
    logic [4:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             bus_ready;

    logic             cmp_valid;
    logic             cmp_ready;
    logic [TAG_W-1:0] cmp_tag;
    logic [31:0]      cmp_expected;
    logic [31:0]      cmp_measured;
    logic             cmp_match;

    modport master (
        output bus_sel, bus_we, bus_addr, bus_wdata, cmp_ready,
        input  bus_rdata, bus_ready, cmp_valid, cmp_tag,
               cmp_expected, cmp_measured, cmp_match
    );

    modport slave (
        input  bus_sel, bus_we, bus_addr, bus_wdata, cmp_ready,
        output bus_rdata, bus_ready, cmp_valid, cmp_tag,
               cmp_expected, cmp_measured, cmp_match
    );
endinterface

// File: rtl/test_result_mailbox.sv
// Memory-mapped mailbox: firmware writes TAG, EXPECTED, then MEASURED, and each
// MEASURED write queues one record for the harness. The block keeps pass/fail
// counts, a sticky failure flag and an end-of-test indication.
module test_result_mailbox #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    test_result_mailbox_if.slave bus,
    output logic                 all_done,
    output logic                 any_fail
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] IDX_TAG     = 3'd0;
    localparam logic [2:0] IDX_EXP     = 3'd1;
    localparam logic [2:0] IDX_MEAS    = 3'd2;
    localparam logic [2:0] IDX_CONTROL = 3'd3;
    localparam logic [2:0] IDX_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [TAG_W-1:0]   tag_reg;
    logic [31:0]        exp_reg;
    logic [TAG_W-1:0]   mem_tag  [DEPTH];
    logic [31:0]        mem_exp  [DEPTH];
    logic [31:0]        mem_meas [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   pass_count;
    logic [CNT_W-1:0]   fail_count;
    logic               fail_flag;
    logic               rd_pending;
    logic [31:0]        rdata_reg;
    logic [31:0]        read_value;

    logic [2:0]         reg_idx;
    logic               wr_access;
    logic               full;
    logic               meas_stall;
    logic               wr_done;
    logic               push;
    logic               pop;
    logic               ctrl_wr;
    logic               done_meas;
    logic               rd_start;
    logic               head_valid;
    logic               head_match;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^bus.bus_addr[1:0];

    assign reg_idx    = bus.bus_addr[4:2];
    assign wr_access  = bus.bus_sel & bus.bus_we;
    assign full       = (level == LVL_W'(DEPTH));
    // The stall looks only at the registered level, so a pop in the same
    // cycle frees the slot one cycle later.
    assign meas_stall = wr_access & (reg_idx == IDX_MEAS) & full & (state != DONE);
    assign wr_done    = wr_access & ~meas_stall;
    assign push       = wr_done & (reg_idx == IDX_MEAS) & (state != DONE);
    assign done_meas  = wr_done & (reg_idx == IDX_MEAS) & (state == DONE);
    assign ctrl_wr    = wr_done & (reg_idx == IDX_CONTROL);
    assign rd_start   = bus.bus_sel & ~bus.bus_we & ~rd_pending;

    assign head_valid = (level != '0);
    assign head_match = head_valid & (mem_exp[rd_ptr] == mem_meas[rd_ptr]);
    assign pop        = head_valid & bus.cmp_ready;

    // Record data is forced to zero whenever the queue head is empty.
    assign bus.cmp_valid    = head_valid;
    assign bus.cmp_tag      = head_valid ? mem_tag[rd_ptr]  : '0;
    assign bus.cmp_expected = head_valid ? mem_exp[rd_ptr]  : '0;
    assign bus.cmp_measured = head_valid ? mem_meas[rd_ptr] : '0;
    assign bus.cmp_match    = head_match;

    // Ready is gated by reset so an access in flight is dropped at once.
    assign bus.bus_ready = reset_n & (wr_done | rd_pending);
    assign bus.bus_rdata = rdata_reg;
    assign any_fail      = fail_flag;

    // Select the register image returned by a read.
    always_comb begin
        read_value = '0;
        case (reg_idx)
            IDX_TAG:    read_value = 32'(tag_reg);
            IDX_EXP:    read_value = exp_reg;
            IDX_STATUS: read_value = {16'(pass_count), fail_count[7:0], 4'(level),
                                      fail_flag, full, state};
            default:    read_value = '0;
        endcase
    end

    // Reads take one cycle: capture data on the strobe, present it with ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rd_pending <= rd_start;
            rdata_reg  <= rd_start ? read_value : '0;
        end
    end

    // TAG and EXPECTED staging registers for the next record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_reg <= '0;
            exp_reg <= '0;
        end else if (wr_done) begin
            if (reg_idx == IDX_TAG) tag_reg <= bus.bus_wdata[TAG_W-1:0];
            if (reg_idx == IDX_EXP) exp_reg <= bus.bus_wdata;
        end
    end

    // Record storage; contents are meaningless while the level says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_tag[wr_ptr]  <= tag_reg;
            mem_exp[wr_ptr]  <= exp_reg;
            mem_meas[wr_ptr] <= bus.bus_wdata;
        end
    end

    // Queue pointers and occupancy level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Saturating pass/fail tallies and the sticky failure flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_flag  <= 1'b0;
        end else begin
            if (pop) begin
                if (head_match) begin
                    if (pass_count != '1) pass_count <= pass_count + 1'b1;
                end else begin
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    fail_flag <= 1'b1;
                end
            end
            if ((ctrl_wr && bus.bus_wdata[1]) || done_meas) fail_flag <= 1'b1;
        end
    end

    // Test phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Phase sequencing and the end-of-test indication.
    always_comb begin
        state_next = state;
        all_done   = 1'b0;
        case (state)
            IDLE:    if (wr_done) state_next = RUN;
            RUN:     if (ctrl_wr && bus.bus_wdata[0]) state_next = DRAIN;
            DRAIN:   if (level == '0) state_next = DONE;
            DONE:    all_done = (level == '0);
            default: state_next = IDLE;
        endcase
    end
endmodule
